// File: rtl/prbs_gen_chk.sv
// ---------------------------------------------------------------------------
// prbs_gen_chk
//   Multi-lane PRBS pattern source and self-synchronising pattern sink, used
//   as a BIST generator/checker pair around loopback paths (delay lines,
//   serdes minitests).
//
//   Generator: a Fibonacci LFSR advanced LANES steps per gen_ce; each step's
//   feedback bit becomes one output bit, oldest bit in the word MSB.
//   Checker: predicts every received bit from the WIDTH previously received
//   bits, so it needs no seed and realigns to any phase of the sequence.
//   A SEEK/LOCKED FSM qualifies the stream; bit errors are only accumulated
//   while LOCKED, in a saturating counter.
//
// Ports
//   clk          in   1          clock
//   rst          in   1          asynchronous active-high reset
//   gen_ce       in   1          advance generator one word
//   gen_inject   in   1          flip gen_data[0] of the word produced this gen_ce
//   gen_data     out  LANES      generated word, MSB = oldest bit
//   gen_valid    out  1          gen_data updated this cycle
//   chk_valid    in   1          chk_data is a word to check
//   chk_data     in   LANES      received word, MSB = oldest bit
//   chk_clr      in   1          synchronous clear of chk_err_cnt
//   chk_locked   out  1          checker in LOCKED
//   chk_err      out  1          pulse: last checked word had >= 1 bit error
//   chk_err_cnt  out  ERR_WIDTH  saturating bit-error count (LOCKED words only)
// ---------------------------------------------------------------------------
module prbs_gen_chk #(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'hD008,
    parameter logic [WIDTH-1:0] SEED       = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int              LANES       = 8,
    parameter int              LOCK_COUNT  = 16,
    parameter int              UNLOCK_ERRS = 4,
    parameter int              ERR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_ce,
    input  logic                 gen_inject,
    output logic [LANES-1:0]     gen_data,
    output logic                 gen_valid,
    input  logic                 chk_valid,
    input  logic [LANES-1:0]     chk_data,
    input  logic                 chk_clr,
    output logic                 chk_locked,
    output logic                 chk_err,
    output logic [ERR_WIDTH-1:0] chk_err_cnt
);

    localparam int NERR_W = $clog2(LANES + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);
    // Adder wide enough for both operands plus a carry, so overflow is visible.
    localparam int SUM_W  = ((ERR_WIDTH > NERR_W) ? ERR_WIDTH : NERR_W) + 1;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Generator
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] gen_r;
    logic [WIDTH-1:0] gen_r_next;
    logic [LANES-1:0] gen_word;

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a variable unassigned (which would infer a latch); the
    // blocking updates inside the loop are intentional -- each step must see
    // the register value produced by the previous step.
    always_comb begin
        gen_r_next = gen_r;
        gen_word   = '0;
        for (int i = 0; i < LANES; i++) begin
            gen_word[LANES-1-i] = ^(gen_r_next & POLY);
            gen_r_next          = {gen_r_next[WIDTH-2:0], gen_word[LANES-1-i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_r     <= SEED;
            gen_data  <= '0;
            gen_valid <= 1'b0;
        end else begin
            gen_valid <= gen_ce;
            if (gen_ce) begin
                gen_r    <= gen_r_next;
                // Injection corrupts the emitted word only; the LFSR stays on
                // the true sequence so exactly one transmitted bit is wrong.
                gen_data <= gen_word ^ LANES'(gen_inject);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Checker datapath
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]     chk_h;
    logic [WIDTH-1:0]     chk_h_next;
    logic [NERR_W-1:0]    nerr;
    logic                 exp_bit;
    logic                 word_err;
    logic [SUM_W-1:0]     cnt_sum;
    logic [ERR_WIDTH-1:0] cnt_sat;

    always_comb begin
        chk_h_next = chk_h;
        nerr       = '0;
        exp_bit    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            exp_bit = ^(chk_h_next & POLY);
            if (chk_data[LANES-1-i] != exp_bit) begin
                nerr = nerr + NERR_W'(1);
            end
            // History is built from what was received, not what was
            // predicted; that is what makes the checker self-synchronising.
            chk_h_next = {chk_h_next[WIDTH-2:0], chk_data[LANES-1-i]};
        end
    end

    assign word_err = (nerr != '0);
    assign cnt_sum  = SUM_W'(chk_err_cnt) + SUM_W'(nerr);
    assign cnt_sat  = (cnt_sum > SUM_W'({ERR_WIDTH{1'b1}})) ? {ERR_WIDTH{1'b1}}
                                                            : cnt_sum[ERR_WIDTH-1:0];

    // -----------------------------------------------------------------------
    // Checker lock FSM and error counter
    // -----------------------------------------------------------------------
    state_t            state;
    logic [GOOD_W-1:0] good_run;
    logic [BAD_W-1:0]  bad_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEEK;
            good_run    <= '0;
            bad_run     <= '0;
            chk_h       <= '0;
            chk_locked  <= 1'b0;
            chk_err     <= 1'b0;
            chk_err_cnt <= '0;
        end else begin
            chk_err <= 1'b0;
            if (chk_valid) begin
                chk_h   <= chk_h_next;
                chk_err <= word_err;
                case (state)
                    SEEK: begin
                        if (word_err) begin
                            good_run <= '0;
                        end else if (good_run == GOOD_W'(LOCK_COUNT - 1)) begin
                            state      <= LOCKED;
                            chk_locked <= 1'b1;
                            good_run   <= '0;
                        end else begin
                            good_run <= good_run + GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!word_err) begin
                            bad_run <= '0;
                        end else if (bad_run == BAD_W'(UNLOCK_ERRS - 1)) begin
                            state      <= SEEK;
                            chk_locked <= 1'b0;
                            bad_run    <= '0;
                        end else begin
                            bad_run <= bad_run + BAD_W'(1);
                        end
                    end
                    default: state <= SEEK;
                endcase
            end

            // Uses the pre-edge state, so the word that causes unlock still
            // counts and the word that causes lock (clean by definition) does not.
            if (chk_clr) begin
                chk_err_cnt <= '0;
            end else if (chk_valid && (state == LOCKED)) begin
                chk_err_cnt <= cnt_sat;
            end
        end
    end

endmodule
